// File: rtl/floppy_pkg.sv
// Shared types and constants for the floppy head positioner.
// Default timing assumes a 10 MHz clock.
package floppy_pkg;

  localparam int TRACK_W = 7;
  typedef logic [TRACK_W-1:0] track_t;

  localparam logic DIR_IN  = 1'b1;
  localparam logic DIR_OUT = 1'b0;

  localparam int DEF_DIR_SETUP_CYC   = 10;
  localparam int DEF_STEP_PULSE_CYC  = 10;
  localparam int DEF_STEP_RATE_CYC   = 80000;
  localparam int DEF_SETTLE_CYC      = 100000;
  localparam int DEF_MAX_TRACK       = 76;
  localparam int DEF_RECAL_MAX_STEPS = 80;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_DIR_SETUP,
    S_STEP_HI,
    S_STEP_LO,
    S_SETTLE,
    S_DONE
  } seek_state_t;

  // One step in direction d, clamped to [0, max_t].
  function automatic track_t step_track(input track_t t, input logic d, input track_t max_t);
    if (d == DIR_IN) return (t >= max_t) ? max_t : track_t'(t + 1'b1);
    return (t == '0) ? '0 : track_t'(t - 1'b1);
  endfunction

endpackage

// File: rtl/floppy_step_timer.sv
// Loadable down-counter; expire is high while the count sits at zero,
// so loading N-1 gives an interval of exactly N cycles.
module floppy_step_timer #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             count <= '0;
    else if (load)          count <= load_val;
    else if (count != '0)   count <= count - 1'b1;
  end

  assign expire = (count == '0);

endmodule

// File: rtl/floppy_seek_ctrl.sv
// Seek/recalibrate controller: drives step/dir/drivenum with setup, pulse,
// step-rate and settle timing, and keeps a track register per drive.
module floppy_seek_ctrl
  import floppy_pkg::*;
#(
  parameter int DIR_SETUP_CYC   = DEF_DIR_SETUP_CYC,
  parameter int STEP_PULSE_CYC  = DEF_STEP_PULSE_CYC,
  parameter int STEP_RATE_CYC   = DEF_STEP_RATE_CYC,
  parameter int SETTLE_CYC      = DEF_SETTLE_CYC,
  parameter int MAX_TRACK       = DEF_MAX_TRACK,
  parameter int RECAL_MAX_STEPS = DEF_RECAL_MAX_STEPS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_recal,
  input  logic [6:0]   cmd_track,
  input  logic         cmd_drive,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [6:0]   cur_track,
  output logic         trk_valid,
  output logic         step,
  output logic         dir,
  output logic         drivenum,
  input  logic         zero_track
);

  localparam int TMR_MAX = (STEP_RATE_CYC > SETTLE_CYC) ? STEP_RATE_CYC : SETTLE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int LO_W    = $clog2(DIR_SETUP_CYC + 1);

  localparam logic [TMR_W-1:0] LD_SETUP  = TMR_W'(DIR_SETUP_CYC - 1);
  localparam logic [TMR_W-1:0] LD_PULSE  = TMR_W'(STEP_PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] LD_LOW    = TMR_W'(STEP_RATE_CYC - STEP_PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] LD_SETTLE = TMR_W'(SETTLE_CYC - 1);
  localparam logic [LO_W-1:0]  LO_FULL   = LO_W'(DIR_SETUP_CYC);
  localparam track_t           MAX_T     = track_t'(MAX_TRACK);
  localparam logic [6:0]       RECAL_LIM = 7'(RECAL_MAX_STEPS);

  seek_state_t      state;
  logic [1:0]       z_sync;
  logic             z;
  logic             recal_q;
  track_t           target;
  logic [6:0]       step_cnt;
  logic [LO_W-1:0]  lo_cnt;
  track_t           track_reg [2];
  logic             cal_reg [2];

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_exp;

  logic at_target, seek_bad, want_dir, skip_setup, chk_finish;
  logic z_mismatch, lo_settle, lo_fail;

  assign z         = z_sync[1];
  assign cmd_ready = (state == S_IDLE);
  assign cur_track = track_reg[drivenum];
  assign trk_valid = cal_reg[drivenum];

  assign at_target  = (cur_track == target);
  assign seek_bad   = (target > MAX_T) || !trk_valid;
  assign want_dir   = recal_q ? DIR_OUT : ((target > cur_track) ? DIR_IN : DIR_OUT);
  assign skip_setup = (dir == want_dir) && (lo_cnt == LO_FULL);
  assign chk_finish = recal_q ? z : (seek_bad || at_target);
  // TRK00 seen while stepping out and the register still claims a nonzero track.
  assign z_mismatch = (dir == DIR_OUT) && z && (cur_track != '0);
  assign lo_settle  = recal_q ? z : (!z_mismatch && at_target);
  assign lo_fail    = recal_q ? (!z && (step_cnt >= RECAL_LIM)) : z_mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) z_sync <= 2'b00;
    else        z_sync <= {z_sync[0], zero_track};
  end

  // Cycles since step last fell, saturating at the direction-setup time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               lo_cnt <= '0;
    else if (step)            lo_cnt <= '0;
    else if (lo_cnt != LO_FULL) lo_cnt <= lo_cnt + 1'b1;
  end

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = LD_PULSE;
    case (state)
      S_CHECK: if (!chk_finish) begin
        tmr_load = 1'b1;
        tmr_val  = skip_setup ? LD_PULSE : LD_SETUP;
      end
      S_DIR_SETUP: tmr_load = tmr_exp;
      S_STEP_HI: begin
        tmr_load = tmr_exp;
        tmr_val  = LD_LOW;
      end
      S_STEP_LO: if (tmr_exp && !lo_fail) begin
        tmr_load = 1'b1;
        tmr_val  = lo_settle ? LD_SETTLE : LD_PULSE;
      end
      default: ;
    endcase
  end

  floppy_step_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      step     <= 1'b0;
      dir      <= DIR_OUT;
      drivenum <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      recal_q  <= 1'b0;
      target   <= '0;
      step_cnt <= '0;
      for (int i = 0; i < 2; i++) begin
        track_reg[i] <= '0;
        cal_reg[i]   <= 1'b0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (cmd_valid) begin
          recal_q  <= cmd_recal;
          target   <= cmd_track;
          drivenum <= cmd_drive;
          busy     <= 1'b1;
          err      <= 1'b0;
          step_cnt <= '0;
          state    <= S_CHECK;
        end
        S_CHECK: begin
          if (chk_finish) begin
            if (recal_q) begin
              track_reg[drivenum] <= '0;
              cal_reg[drivenum]   <= 1'b1;
            end
            err   <= !recal_q && seek_bad;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            // Head position is unknown once a recal starts stepping blind.
            if (recal_q) cal_reg[drivenum] <= 1'b0;
            dir <= want_dir;
            if (skip_setup) begin
              step  <= 1'b1;
              state <= S_STEP_HI;
            end else begin
              state <= S_DIR_SETUP;
            end
          end
        end
        S_DIR_SETUP: if (tmr_exp) begin
          step  <= 1'b1;
          state <= S_STEP_HI;
        end
        S_STEP_HI: if (tmr_exp) begin
          step     <= 1'b0;
          step_cnt <= step_cnt + 1'b1;
          if (!recal_q) track_reg[drivenum] <= step_track(cur_track, dir, MAX_T);
          state    <= S_STEP_LO;
        end
        S_STEP_LO: if (tmr_exp) begin
          if (lo_fail) begin
            if (!recal_q) track_reg[drivenum] <= '0;
            err   <= 1'b1;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (lo_settle) begin
            if (recal_q) begin
              track_reg[drivenum] <= '0;
              cal_reg[drivenum]   <= 1'b1;
            end
            state <= S_SETTLE;
          end else begin
            step  <= 1'b1;
            state <= S_STEP_HI;
          end
        end
        S_SETTLE: if (tmr_exp) begin
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
